// File: rtl/dd_scan_ctrl.sv
// -----------------------------------------------------------------------------
// dd_scan_ctrl
//   Scan controller for a 4-digit multiplexed 7-segment display. The four
//   ASCII characters are time-multiplexed onto one shared segment bus and four
//   digit gates. Each digit slot starts with a dark (blanking) gap so that the
//   segment bus can settle without ghosting into the neighbouring digit.
//   CPU writes land in a shadow buffer. They are copied into the active buffer
//   only at a frame boundary, which is the last cycle of digit 3. While the
//   scan is idle, the copy happens on the next cycle instead.
//
// Ports
//   clk        in   1   system clock
//   rst        in   1   synchronous reset, active-high
//   enable     in   1   1 = scan running, 0 = display dark and controller idle
//   wrEnable   in   1   one-cycle write strobe for wrData
//   wrData     in   32  four ASCII chars, [31:24] = digit0 .. [7:0] = digit3
//   ddOut      out  8   segments {dp,g,f,e,d,c,b,a}, registered
//   ddGate     out  4   digit gates, bit i = digit i, registered
//   pending    out  1   a write was accepted but is not yet displayed
//   frameTick  out  1   one-cycle pulse: a frame began with newly committed data
// -----------------------------------------------------------------------------
module dd_scan_ctrl #(
  parameter logic [27:0] DIGIT_PERIOD = 28'h3000,
  parameter logic [27:0] BLANK_CYCLES = 28'h0100,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        wrEnable,
  input  logic [31:0] wrData,
  output logic [7:0]  ddOut,
  output logic [3:0]  ddGate,
  output logic        pending,
  output logic        frameTick
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } state_t;

  localparam logic [31:0] SPACES   = 32'h20202020;
  localparam logic [7:0]  SEG_OFF  = ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [3:0]  GATE_OFF = ACTIVE_LOW ? 4'hF : 4'h0;

  // ASCII to active-high {g,f,e,d,c,b,a}. Codes without a glyph stay blank.
  function automatic logic [6:0] decodeChar(input logic [7:0] ch);
    logic [6:0] seg;
    case (ch)
      8'h30:        seg = 7'h3F; // 0
      8'h31:        seg = 7'h06; // 1
      8'h32:        seg = 7'h5B; // 2
      8'h33:        seg = 7'h4F; // 3
      8'h34:        seg = 7'h66; // 4
      8'h35:        seg = 7'h6D; // 5
      8'h36:        seg = 7'h7D; // 6
      8'h37:        seg = 7'h07; // 7
      8'h38:        seg = 7'h7F; // 8
      8'h39:        seg = 7'h6F; // 9
      8'h41, 8'h61: seg = 7'h77; // A
      8'h42, 8'h62: seg = 7'h7C; // b
      8'h43, 8'h63: seg = 7'h39; // C
      8'h44, 8'h64: seg = 7'h5E; // d
      8'h45, 8'h65: seg = 7'h79; // E
      8'h46, 8'h66: seg = 7'h71; // F
      8'h2D:        seg = 7'h40; // '-' lights only the middle bar
      default:      seg = 7'h00;
    endcase
    return seg;
  endfunction

  state_t      state_r, stateNext_s;
  logic [27:0] slotCnt_r, slotNext_s;
  logic [1:0]  digit_r, digitNext_s;
  logic [31:0] active_r;
  logic [31:0] shadow_r;
  logic [7:0]  charSel_s;
  logic [7:0]  segAct_s;
  logic [3:0]  gateAct_s;
  logic [7:0]  ddOutNext_s;
  logic [3:0]  ddGateNext_s;
  logic        frameCommit_s;
  logic        idleCommit_s;

  // Scan sequencing: next state, slot counter and digit index.
  always_comb begin
    stateNext_s = state_r;
    slotNext_s  = slotCnt_r;
    digitNext_s = digit_r;
    if (!enable) begin
      stateNext_s = ST_IDLE;
      slotNext_s  = 28'd0;
      digitNext_s = 2'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          stateNext_s = ST_BLANK;
          slotNext_s  = 28'd0;
          digitNext_s = 2'd0;
        end
        ST_BLANK: begin
          slotNext_s = slotCnt_r + 28'd1;
          if (slotCnt_r == BLANK_CYCLES - 28'd1) begin
            stateNext_s = ST_DRIVE;
          end else begin
            stateNext_s = ST_BLANK;
          end
        end
        ST_DRIVE: begin
          if (slotCnt_r == DIGIT_PERIOD - 28'd1) begin
            stateNext_s = ST_BLANK;
            slotNext_s  = 28'd0;
            digitNext_s = digit_r + 2'd1;
          end else begin
            stateNext_s = ST_DRIVE;
            slotNext_s  = slotCnt_r + 28'd1;
          end
        end
        default: begin
          stateNext_s = ST_IDLE;
          slotNext_s  = 28'd0;
          digitNext_s = 2'd0;
        end
      endcase
    end
  end

  // Pin values for the coming cycle. They are derived from the next state so
  // that the output registers line up with the state register. A commit only
  // happens when the next state is BLANK or IDLE, so using active_r here never
  // shows stale data.
  always_comb begin
    case (digitNext_s)
      2'd0:    charSel_s = active_r[31:24];
      2'd1:    charSel_s = active_r[23:16];
      2'd2:    charSel_s = active_r[15:8];
      2'd3:    charSel_s = active_r[7:0];
      default: charSel_s = 8'h20;
    endcase
    if (stateNext_s == ST_DRIVE) begin
      gateAct_s = 4'b0001 << digitNext_s;
      segAct_s  = {1'b0, decodeChar(charSel_s)};
    end else begin
      gateAct_s = 4'b0000;
      segAct_s  = 8'h00;
    end
    if (ACTIVE_LOW) begin
      ddOutNext_s  = ~segAct_s;
      ddGateNext_s = ~gateAct_s;
    end else begin
      ddOutNext_s  = segAct_s;
      ddGateNext_s = gateAct_s;
    end
  end

  // Commit points: the last cycle of digit 3 while scanning, or any cycle in IDLE.
  always_comb begin
    frameCommit_s = enable && pending && (state_r == ST_DRIVE) &&
                    (digit_r == 2'd3) && (slotCnt_r == DIGIT_PERIOD - 28'd1);
    idleCommit_s  = pending && (state_r == ST_IDLE);
  end

  // State, buffers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      slotCnt_r <= 28'd0;
      digit_r   <= 2'd0;
      active_r  <= SPACES;
      shadow_r  <= SPACES;
      pending   <= 1'b0;
      frameTick <= 1'b0;
      ddOut     <= SEG_OFF;
      ddGate    <= GATE_OFF;
    end else begin
      state_r   <= stateNext_s;
      slotCnt_r <= slotNext_s;
      digit_r   <= digitNext_s;
      ddOut     <= ddOutNext_s;
      ddGate    <= ddGateNext_s;
      frameTick <= frameCommit_s;
      if (wrEnable) begin
        shadow_r <= wrData;
      end else begin
        shadow_r <= shadow_r;
      end
      // A write that arrives in the commit cycle bypasses the shadow buffer,
      // so the newest data is the data that gets committed.
      if (frameCommit_s || idleCommit_s) begin
        active_r <= wrEnable ? wrData : shadow_r;
        pending  <= 1'b0;
      end else if (wrEnable) begin
        active_r <= active_r;
        pending  <= 1'b1;
      end else begin
        active_r <= active_r;
        pending  <= pending;
      end
    end
  end

endmodule

// File: tb/tb_dd_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dd_scan_ctrl
//   Scoreboard bench for dd_scan_ctrl with DIGIT_PERIOD=8, BLANK_CYCLES=2 and
//   ACTIVE_LOW=1. On every cycle, the stimulus pushes the pin values expected
//   after the next clock edge. The monitor pops and compares them once per
//   cycle.
// -----------------------------------------------------------------------------
module tb_dd_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        wrEnable;
  logic [31:0] wrData;
  logic [7:0]  ddOut;
  logic [3:0]  ddGate;
  logic        pending;
  logic        frameTick;

  always #5 clk = ~clk;

  dd_scan_ctrl #(
    .DIGIT_PERIOD(28'd8),
    .BLANK_CYCLES(28'd2),
    .ACTIVE_LOW  (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .wrEnable (wrEnable),
    .wrData   (wrData),
    .ddOut    (ddOut),
    .ddGate   (ddGate),
    .pending  (pending),
    .frameTick(frameTick)
  );

  typedef struct {
    logic [7:0] seg;
    logic [3:0] gate;
    logic       pend;
    logic       tick;
    int         step;
  } exp_t;

  exp_t sbq[$];
  int   tests  = 0;
  int   fails  = 0;
  int   stepNo = 0;

  logic [3:0] gateOn [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  // Hand-computed active-low segment words, {digit0, digit1, digit2, digit3}.
  localparam logic [31:0] SEG_123A = 32'hF9A4B088; // "123A"
  localparam logic [31:0] SEG_Z0   = 32'hBFFFFFC0; // "-Z 0"
  localparam logic [31:0] SEG_EF8  = 32'h868EBF80; // "Ef-8"
  localparam logic [31:0] SEG_SPC  = 32'hFFFFFFFF; // "    "

  // One cycle: drive the inputs and queue the pins expected after the next edge.
  task automatic cyc(input logic r, input logic e, input logic we, input logic [31:0] d,
                     input logic [7:0] s, input logic [3:0] g, input logic p, input logic t);
    exp_t x;
    @(posedge clk);
    #2;
    rst      = r;
    enable   = e;
    wrEnable = we;
    wrData   = d;
    x.seg  = s;
    x.gate = g;
    x.pend = p;
    x.tick = t;
    x.step = stepNo;
    sbq.push_back(x);
    stepNo++;
  endtask

  // One 32-cycle frame with enable held high. Index k is the output after
  // the k-th edge of the frame. Up to three writes can be placed in the frame.
  // stopIdx ends the frame early by dropping enable, and also asserts rst
  // when stopRst is set.
  task automatic frame(input logic [31:0] segs, input logic tick,
                       input logic w0, input logic [31:0] d0,
                       input int wA, input logic [31:0] dA,
                       input int wB, input logic [31:0] dB,
                       input int stopIdx, input logic stopRst);
    logic p;
    p = 1'b0;
    for (int k = 0; k < 32; k++) begin
      int          dg;
      int          ps;
      logic        we;
      logic [31:0] wd;
      logic [7:0]  s;
      logic [3:0]  g;
      dg = k / 8;
      ps = k % 8;
      we = 1'b0;
      wd = 32'h0000_0000;
      if (k == 0 && w0) begin
        we = 1'b1;
        wd = d0;
      end else if (k == wA) begin
        we = 1'b1;
        wd = dA;
        p  = 1'b1;
      end else if (k == wB) begin
        we = 1'b1;
        wd = dB;
        p  = 1'b1;
      end
      if (ps < 2) begin
        s = 8'hFF;
        g = 4'hF;
      end else begin
        s = segs[31 - 8*dg -: 8];
        g = gateOn[dg];
      end
      if (k == stopIdx) begin
        cyc(stopRst, 1'b0, 1'b0, 32'h0, 8'hFF, 4'hF, stopRst ? 1'b0 : p, 1'b0);
        return;
      end
      cyc(1'b0, 1'b1, we, wd, s, g, p, (k == 0) && tick);
    end
  endtask

  // Monitor: one expected entry per cycle, compared just after the edge.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      tests++;
      if ({ddOut, ddGate, pending, frameTick} !== {e.seg, e.gate, e.pend, e.tick}) begin
        fails++;
        $display("FAIL pins step %0d: got ddOut=%h ddGate=%h pending=%b frameTick=%b, expected ddOut=%h ddGate=%h pending=%b frameTick=%b",
                 e.step, ddOut, ddGate, pending, frameTick, e.seg, e.gate, e.pend, e.tick);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    enable   = 1'b0;
    wrEnable = 1'b0;
    wrData   = 32'h0;

    // Reset, then the display stays dark while enable is low.
    repeat (3) cyc(1'b1, 1'b0, 1'b0, 32'h0, 8'hFF, 4'hF, 1'b0, 1'b0);
    repeat (4) cyc(1'b0, 1'b0, 1'b0, 32'h0, 8'hFF, 4'hF, 1'b0, 1'b0);

    // Write "123A" while idle. pending pulses for one cycle, then the scan starts.
    cyc(1'b0, 1'b0, 1'b1, 32'h31323341, 8'hFF, 4'hF, 1'b1, 1'b0);
    frame(SEG_123A, 1'b0, 1'b0, 32'h0, -1, 32'h0, -1, 32'h0, 99, 1'b0);
    frame(SEG_123A, 1'b0, 1'b0, 32'h0, -1, 32'h0, -1, 32'h0, 99, 1'b0);

    // Mid-frame write of "-Z 0". The old glyphs stay until the frame boundary.
    frame(SEG_123A, 1'b0, 1'b0, 32'h0, 10, 32'h2D5A2030, -1, 32'h0, 99, 1'b0);
    // The new frame ticks. Two writes are made, and the last write wins.
    frame(SEG_Z0, 1'b1, 1'b0, 32'h0, 5, 32'h31313131, 20, 32'h32323232, 99, 1'b0);
    // "Ef-8" is written exactly in the commit cycle and is shown at once.
    frame(SEG_EF8, 1'b1, 1'b1, 32'h45662D38, -1, 32'h0, -1, 32'h0, 99, 1'b0);
    frame(SEG_EF8, 1'b0, 1'b0, 32'h0, -1, 32'h0, -1, 32'h0, 99, 1'b0);

    // Drop enable during DRIVE of digit 2, idle, then restart at digit 0.
    frame(SEG_EF8, 1'b0, 1'b0, 32'h0, -1, 32'h0, -1, 32'h0, 20, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 32'h0, 8'hFF, 4'hF, 1'b0, 1'b0);
    frame(SEG_EF8, 1'b0, 1'b0, 32'h0, -1, 32'h0, -1, 32'h0, 99, 1'b0);

    // Reset mid-frame with a pending write. The shadow write is lost and spaces show.
    frame(SEG_EF8, 1'b0, 1'b0, 32'h0, 5, 32'h31323341, -1, 32'h0, 12, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 32'h0, 8'hFF, 4'hF, 1'b0, 1'b0);
    frame(SEG_SPC, 1'b0, 1'b0, 32'h0, -1, 32'h0, -1, 32'h0, 99, 1'b0);
    frame(SEG_SPC, 1'b0, 1'b0, 32'h0, -1, 32'h0, -1, 32'h0, 99, 1'b0);

    repeat (3) @(posedge clk);
    #3;
    tests++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d unchecked entries, expected 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
